// File: rtl/hilo_mac.sv
// Multicycle HI/LO multiply-accumulate unit: radix-2 shift-add over W cycles,
// then a single commit that writes, adds to or subtracts from the HiLo pair.
module hilo_mac #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi_out,
    output logic [W-1:0] lo_out
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, MUL, COMMIT} state_t;

    state_t         state_reg;
    logic [2*W-1:0] hilo_reg;
    logic [2*W-1:0] prod_reg;
    logic [W-1:0]   mcand_reg;
    logic [CW-1:0]  count_reg;
    logic [1:0]     kind_reg;
    logic           negate_reg;
    logic           busy_reg;
    logic           done_reg;

    logic           is_signed;
    logic           rs_neg;
    logic           rt_neg;
    logic [W-1:0]   rs_mag;
    logic [W-1:0]   rt_mag;
    logic [W:0]     sum_next;
    logic [2*W-1:0] prod_next;
    logic [2*W-1:0] signed_prod;
    logic [2*W-1:0] hilo_next;
    logic           last_step;

    // Even multiply opcodes are the signed variants.
    assign is_signed = ~op[0];
    assign rs_neg    = is_signed & rs_val[W-1];
    assign rt_neg    = is_signed & rt_val[W-1];
    // Magnitude of the most-negative value is 2^(W-1), which still fits unsigned.
    assign rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;

    // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
    assign sum_next  = {1'b0, prod_reg[2*W-1:W]} + {1'b0, (prod_reg[0] ? mcand_reg : {W{1'b0}})};
    assign prod_next = {sum_next, prod_reg[W-1:1]};
    assign last_step = (count_reg == CW'(W - 1));

    assign signed_prod = negate_reg ? (~prod_reg + 1'b1) : prod_reg;

    always_comb begin
        hilo_next = signed_prod;
        case (kind_reg)
            2'b01:   hilo_next = hilo_reg + signed_prod;
            2'b10:   hilo_next = hilo_reg - signed_prod;
            default: hilo_next = signed_prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            hilo_reg   <= '0;
            prod_reg   <= '0;
            mcand_reg  <= '0;
            count_reg  <= '0;
            kind_reg   <= 2'b00;
            negate_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !flush) begin
                        if (op[2:1] == 2'b11) begin
                            if (op[0]) hilo_reg[W-1:0]   <= rs_val;
                            else       hilo_reg[2*W-1:W] <= rs_val;
                        end else begin
                            kind_reg   <= op[2:1];
                            negate_reg <= rs_neg ^ rt_neg;
                            mcand_reg  <= rs_mag;
                            prod_reg   <= {{W{1'b0}}, rt_mag};
                            count_reg  <= '0;
                            busy_reg   <= 1'b1;
                            state_reg  <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        prod_reg  <= prod_next;
                        count_reg <= count_reg + 1'b1;
                        if (last_step) begin
                            done_reg  <= 1'b1;
                            state_reg <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (!flush) hilo_reg <= hilo_next;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // A flush landing in COMMIT kills the pulse along with the write.
    assign done   = done_reg & ~flush;
    assign busy   = busy_reg;
    assign hi_out = hilo_reg[2*W-1:W];
    assign lo_out = hilo_reg[W-1:0];
endmodule
